// File: rtl/tinker_run_controller.sv
// Tinker CPU run controller: streams a program image into CPU memory, runs the CPU,
// and captures its output beats. Define RUN_CTRL_CYCLE_CNT_EN to add a 32-bit run_cycles output.
module tinker_run_controller #(
    parameter int ADDR_W     = 16,
    parameter int LOAD_BASE  = 0,
    parameter int DATA_W     = 64,
    parameter int OUT_DEPTH  = 8,
    parameter int MAX_CYCLES = 155
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [7:0]        load_data,
    input  logic              load_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_reset,
    input  logic              cpu_halt,
    input  logic              cpu_out_signal,
    input  logic [DATA_W-1:0] cpu_out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              halted,
    output logic              timeout,
    output logic              load_err,
    output logic              out_overflow
`ifdef RUN_CTRL_CYCLE_CNT_EN
    ,
    output logic [31:0]       run_cycles
`endif
);

    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);
    localparam logic [ADDR_W-1:0] ADDR_TOP  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(LOAD_BASE);
    localparam logic [CNT_W-1:0]  CYC_LAST  = CNT_W'(MAX_CYCLES - 1);
    localparam logic [PTR_W:0]    FIFO_FULL = (PTR_W + 1)'(OUT_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic              vld_p1;
    logic              last_p1;
    logic [7:0]        wdata_p1;
    logic [CNT_W-1:0]  cyc_cnt;
    logic              set_halt, set_timeout, set_lerr;
    logic              at_top, accept, launch;
    logic              push, pop, full, do_push;
    logic [DATA_W-1:0] fifo_mem [OUT_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    fifo_cnt;

    assign at_top     = (mem_addr == ADDR_TOP);
    // Stop taking bytes while the final (or address-exhausting) write is in flight.
    assign load_ready = (state == S_LOAD) && !(vld_p1 && (last_p1 || at_top));
    assign accept     = load_valid && load_ready;
    assign launch     = start && !abort && ((state == S_IDLE) || (state == S_DONE));

    assign push       = (state == S_RUN) && cpu_out_signal;
    assign out_valid  = (fifo_cnt != '0);
    assign full       = (fifo_cnt == FIFO_FULL);
    assign pop        = out_ready && out_valid;
    assign do_push    = push && (!full || pop);
    assign out_data   = out_valid ? fifo_mem[rd_ptr] : '0;

    assign mem_we     = vld_p1;
    assign mem_wdata  = vld_p1 ? wdata_p1 : 8'h00;
    assign cpu_reset  = (state != S_RUN);
    assign busy       = (state == S_LOAD) || (state == S_RUN);
    assign done       = (state == S_DONE);

    always_comb begin
        state_nxt   = state;
        set_halt    = 1'b0;
        set_timeout = 1'b0;
        set_lerr    = 1'b0;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start) state_nxt = S_LOAD;
                S_LOAD: begin
                    if (vld_p1) begin
                        if (last_p1) begin
                            state_nxt = S_RUN;
                        end else if (at_top) begin
                            state_nxt = S_DONE;
                            set_lerr  = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (cpu_halt) begin
                        state_nxt = S_DONE;
                        set_halt  = 1'b1;
                    end else if (cyc_cnt == CYC_LAST) begin
                        state_nxt   = S_DONE;
                        set_timeout = 1'b1;
                    end
                end
                S_DONE: if (start) state_nxt = S_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            cyc_cnt      <= '0;
            halted       <= 1'b0;
            timeout      <= 1'b0;
            load_err     <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_LOAD) begin
                cyc_cnt <= '0;
            end else if (state == S_RUN) begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
            if (launch) begin
                halted       <= 1'b0;
                timeout      <= 1'b0;
                load_err     <= 1'b0;
                out_overflow <= 1'b0;
            end else begin
                if (set_halt)              halted       <= 1'b1;
                if (set_timeout)           timeout      <= 1'b1;
                if (set_lerr)              load_err     <= 1'b1;
                if (push && full && !pop)  out_overflow <= 1'b1;
            end
        end
    end

    // Stage p0 -> p1: an accepted image byte becomes a memory write one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
            mem_addr <= '0;
        end else begin
            vld_p1  <= accept;
            last_p1 <= load_last;
            if (launch) begin
                mem_addr <= ADDR_BASE;
            end else if (vld_p1 && !at_top) begin
                mem_addr <= mem_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) wdata_p1 <= load_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (launch) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) fifo_mem[wr_ptr] <= cpu_out_data;
    end

`ifdef RUN_CTRL_CYCLE_CNT_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cycles <= '0;
        end else if (launch) begin
            run_cycles <= '0;
        end else if (state == S_RUN) begin
            run_cycles <= sat_inc32(run_cycles);
        end
    end
`endif

endmodule
